// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared constants and types for the cache fill FSM and the cache arrays.
//   BLOCK_WORDS / WORD_BYTES : block geometry (8 words of 2 bytes)
//   BLOCK_MASK               : clears the in-block byte offset of an address
//   fill_state_e             : IDLE/FILL encoding of the refill FSM
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int CNT_W       = 3;
    localparam int BLOCK_WORDS = 8;
    localparam int WORD_BYTES  = 2;

    localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm_if
// Groups the CPU-side miss signals, the memory read channel and the
// data/tag array write port of the refill FSM.
//   master : the fill FSM (drives stall, memory reads and array writes)
//   slave  : the surroundings (CPU miss detect, main memory, arrays)
// ---------------------------------------------------------------------------
interface cache_fill_fsm_if;
    import cache_pkg::*;

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic [DATA_W-1:0] memory_data;
    logic              memory_data_valid;
    logic              fsm_busy;
    logic              memory_read_en;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [CNT_W-1:0]  data_word_sel;
    logic [DATA_W-1:0] fill_data;
    logic              write_tag_array;

    modport master (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output fsm_busy, memory_read_en, memory_address,
               write_data_array, data_word_sel, fill_data, write_tag_array
    );

    modport slave (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  fsm_busy, memory_read_en, memory_address,
               write_data_array, data_word_sel, fill_data, write_tag_array
    );

endinterface

// File: rtl/fill_counter.sv
// ---------------------------------------------------------------------------
// fill_counter
// 3-bit word counter with synchronous clear and count enable.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : increment this cycle
//   cnt      : current count
//   tc       : count equals LAST (terminal count)
// ---------------------------------------------------------------------------
module fill_counter
    import cache_pkg::*;
#(
    parameter logic [CNT_W-1:0] LAST = 3'd7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
// Refills one cache block from main memory after a miss: latches the block
// base, streams BLOCK_WORDS reads on consecutive cycles, writes each returned
// word into the data array in arrival order and writes the tag with the last.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cache_fill_fsm_if.master (miss in, memory read channel,
//              data/tag array write port, fsm_busy stall)
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
    parameter int WORD_BYTES  = cache_pkg::WORD_BYTES
) (
    input  logic            clk,
    input  logic            rst,
    cache_fill_fsm_if.master bus
);

    localparam int AW = cache_pkg::ADDR_W;
    localparam int CW = cache_pkg::CNT_W;
    localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);

    cache_pkg::fill_state_e state_q, state_d, state_eff;
    logic [AW-1:0]          block_base_q, block_base_d;
    logic                   issue_done_q, issue_done_d;

    logic          issue_en, rcv_en, cnt_clr;
    logic [CW-1:0] issue_cnt, rcv_cnt;
    logic          issue_tc, rcv_tc;

    fill_counter #(.LAST(LAST_WORD)) u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (issue_en),
        .cnt (issue_cnt),
        .tc  (issue_tc)
    );

    fill_counter #(.LAST(LAST_WORD)) u_rcv_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (rcv_en),
        .cnt (rcv_cnt),
        .tc  (rcv_tc)
    );

    // While rst is high the outputs must already look like IDLE, so the
    // output decode runs on an effective state rather than the raw flop.
    assign state_eff = rst ? cache_pkg::IDLE : state_q;

    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d               = state_q;
        block_base_d          = block_base_q;
        issue_done_d          = issue_done_q;
        issue_en              = 1'b0;
        rcv_en                = 1'b0;
        cnt_clr               = 1'b0;
        bus.fsm_busy          = bus.miss_detected;
        bus.memory_read_en    = 1'b0;
        bus.memory_address    = '0;
        bus.write_data_array  = 1'b0;
        bus.data_word_sel     = '0;
        bus.fill_data         = bus.memory_data;
        bus.write_tag_array   = 1'b0;

        case (state_eff)
            cache_pkg::IDLE: begin
                if (bus.miss_detected) begin
                    state_d      = cache_pkg::FILL;
                    block_base_d = bus.miss_address & cache_pkg::BLOCK_MASK;
                    issue_done_d = 1'b0;
                end
            end

            cache_pkg::FILL: begin
                bus.fsm_busy      = 1'b1;
                bus.data_word_sel = rcv_cnt;

                // The counter holds at the last word; issue_done marks that
                // the last read has also gone out.
                if (!issue_done_q) begin
                    bus.memory_read_en = 1'b1;
                    bus.memory_address = block_base_q
                                       + AW'(issue_cnt) * AW'(WORD_BYTES);
                    issue_en           = !issue_tc;
                    issue_done_d       = issue_tc;
                end

                // Responses return in issue order, so rcv_cnt is the word index.
                if (bus.memory_data_valid) begin
                    bus.write_data_array = 1'b1;
                    rcv_en               = 1'b1;
                    if (rcv_tc) begin
                        bus.write_tag_array = 1'b1;
                        state_d             = cache_pkg::IDLE;
                        cnt_clr             = 1'b1;
                        issue_done_d        = 1'b0;
                    end
                end
            end

            default: state_d = cache_pkg::IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= cache_pkg::IDLE;
            block_base_q <= '0;
            issue_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            block_base_q <= block_base_d;
            issue_done_q <= issue_done_d;
        end
    end

endmodule
